ais_frame_gate: RTL and testbench
=================================

Name: ais_frame_gate

Overview:
- Sits directly downstream of the AIS frame detector.
- Consumes the detector's IQ stream and start-of-frame flag (s_axis_tuser), and gates out one fixed-length frame of IQ samples per detected start.
- Frames are buffered in a small FIFO and emitted on an AXI-Stream master with first/abort markers and tlast, for the demodulator stage.
- The detector has no backpressure, so this block absorbs rate mismatch and reports loss instead of stalling upstream.

Parameters:
- PAR_DATA_WIDTH, 16: width of each of I and Q; signed.
- PAR_FRAME_SAMPLES, 2112: samples per emitted frame, (256+8) symbols * 8 SPS; must be >= 2.
- PAR_FIFO_DEPTH, 16: FIFO entries; power of two, >= 4.
- PAR_CNT_WIDTH, 16: width of o_frame_cnt.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset.
- s_axis_tvalid, input, 1: input sample valid.
- s_axis_tdata, input, 2*PAR_DATA_WIDTH: I in [0 +: PAR_DATA_WIDTH], Q in [PAR_DATA_WIDTH +: PAR_DATA_WIDTH].
- s_axis_tuser, input, 1: start-of-frame, qualified by s_axis_tvalid.
- m_axis_tvalid, output, 1: output entry valid.
- m_axis_tready, input, 1: downstream ready.
- m_axis_tdata, output, 2*PAR_DATA_WIDTH: IQ sample, same packing as input.
- m_axis_tuser, output, 2: [0] first sample of frame; [1] abort marker.
- m_axis_tlast, output, 1: last entry of frame (normal or abort).
- o_busy, output, 1: state != IDLE.
- o_overflow, output, 1: sticky; set on any dropped sample.
- o_frame_cnt, output, PAR_CNT_WIDTH: count of completed (non-aborted) frames; wraps.

Behaviour:
- Reset and clocking: i_rst_n is synchronous, active-low; clock i_clk.
- Reset values: state IDLE, FIFO empty, m_axis_tvalid=0, m_axis_tdata/tuser/tlast=0, o_busy=0, o_overflow=0, o_frame_cnt=0, sample counter 0.
- Reset mid-frame discards all FIFO contents and the partial frame. No tlast is emitted for it.
- s_axis_tready does not exist: input is accepted every cycle s_axis_tvalid=1.
- FIFO "full" is evaluated before the same-cycle read. A write while full is an overflow, even if m_axis_tready=1 that cycle.
- FIFO entry layout: {last, abort, first, tdata}.
- Output is registered, first-word-fall-through. An entry written at cycle t is visible on m_axis_* at t+1 at the earliest.
- m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- State IDLE:
  - Samples are discarded unless s_axis_tvalid & s_axis_tuser.
  - On SOF with FIFO not full: write {0,0,1,sample}, counter=1, go CAPTURE.
  - On SOF with FIFO full: drop it, set o_overflow, stay IDLE.
- State CAPTURE, on each valid sample:
  - s_axis_tuser is ignored; a re-detect inside a frame does not restart it.
  - If FIFO not full and counter==PAR_FRAME_SAMPLES-1: write with last=1, o_frame_cnt++, go IDLE.
  - Otherwise, if FIFO not full: write, counter++.
  - If FIFO full: drop the sample, set o_overflow, go ABORT.
- State ABORT:
  - All input is discarded.
  - On the first cycle the FIFO is not full: write {1,1,0,0}, go IDLE. o_frame_cnt is unchanged.
- A SOF arriving in the same cycle the last sample is written belongs to the old frame and is ignored. The next SOF is accepted from the following cycle.
- A frame in progress is never split by new SOFs; every frame that starts ends with exactly one tlast entry.
- FIFO pointers are log2(PAR_FIFO_DEPTH)+1 bits, with wrap detection by MSB. Occupancy never exceeds PAR_FIFO_DEPTH.
- o_frame_cnt wraps from 2^PAR_CNT_WIDTH-1 to 0.

Test Plan (bench parameters PAR_FRAME_SAMPLES=20, PAR_FIFO_DEPTH=8):
- Continuous valid, ramp data 0..99, tuser at sample 10, m_axis_tready=1 -> 20 outputs with data 10..29; first on 10, last on 29; o_frame_cnt=1; o_overflow=0; first output one cycle after input sample 10.
- Same stream plus tuser at samples 15 and 29 -> still exactly one frame of data 10..29; SOF at 29 ignored; a second SOF at 30 starts a frame with data 30..49.
- tuser at 10, m_axis_tready=0 -> 8 entries (data 10..17) held; sample 18 dropped; o_overflow=1; state ABORT. Then m_axis_tready=1 -> outputs 10..17 followed by an abort entry (tuser=2'b10, tlast=1, data 0); o_frame_cnt=0.
- Random m_axis_tready with 50% duty, valid every 3rd cycle, 5 SOFs spaced 70 samples apart -> 5 complete frames, o_frame_cnt=5, o_overflow=0, data bit-exact with the input ramp.
- Assert i_rst_n=0 for 1 cycle at frame sample 7 -> next cycle m_axis_tvalid=0, o_busy=0, o_frame_cnt=0; a later SOF starts a fresh 20-sample frame.

Source files
------------

// File: rtl/ais_frame_gate_if.sv
// AXI-Stream style bus bundle for the AIS frame gate: the detector-side IQ
// input (no backpressure) and the demodulator-side output stream.
interface ais_frame_gate_if #(
  parameter int PAR_DATA_WIDTH = 16
);
  logic                        s_axis_tvalid;
  logic [2*PAR_DATA_WIDTH-1:0] s_axis_tdata;
  logic                        s_axis_tuser;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [2*PAR_DATA_WIDTH-1:0] m_axis_tdata;
  logic [1:0]                  m_axis_tuser;
  logic                        m_axis_tlast;

  // The frame gate itself: consumes the input stream, drives the output stream.
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  // The surroundings: detector feeding samples, demodulator taking frames.
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tuser, m_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/ais_frame_gate.sv
// AIS frame gate: on each start-of-frame from the detector, captures a fixed
// number of IQ samples into a small FIFO and emits them as one frame with
// first/abort markers and tlast. The detector cannot be stalled, so a full
// FIFO drops samples, flags overflow and closes the frame with an abort entry.
module ais_frame_gate #(
  parameter int PAR_DATA_WIDTH    = 16,
  parameter int PAR_FRAME_SAMPLES = 2112,
  parameter int PAR_FIFO_DEPTH    = 16,
  parameter int PAR_CNT_WIDTH     = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  ais_frame_gate_if.slave          axis,
  output logic                     o_busy,
  output logic                     o_overflow,
  output logic [PAR_CNT_WIDTH-1:0] o_frame_cnt
);

  localparam int TW = 2 * PAR_DATA_WIDTH;
  localparam int EW = TW + 3;
  localparam int AW = $clog2(PAR_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(PAR_FRAME_SAMPLES + 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(PAR_FRAME_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, ABORT} state_t;

  state_t        state;
  logic [SW-1:0] smp_cnt;

  // FIFO entry: {last, abort, first, tdata}
  logic [EW-1:0] mem [PAR_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          fifo_full, fifo_empty_n, wr_en, rd_fire, sof;
  logic [EW-1:0] wr_entry, head_n;

  // Full is judged on the registered pointers, i.e. before any same-cycle read.
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign sof       = axis.s_axis_tvalid & axis.s_axis_tuser;
  assign rd_fire   = axis.m_axis_tvalid & axis.m_axis_tready;
  assign rd_ptr_n  = rd_ptr + PW'(rd_fire);
  assign wr_ptr_n  = wr_ptr + PW'(wr_en);
  assign fifo_empty_n = (wr_ptr_n == rd_ptr_n);

  // Next head of queue; an entry landing in an otherwise empty FIFO bypasses memory.
  assign head_n = (wr_en && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) ?
                  wr_entry : mem[rd_ptr_n[AW-1:0]];

  // Decide whether this cycle writes the FIFO and what the entry looks like.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = {3'b000, axis.s_axis_tdata};
    case (state)
      IDLE: begin
        if (sof && !fifo_full) begin
          wr_en    = 1'b1;
          wr_entry = {3'b001, axis.s_axis_tdata};
        end
      end
      CAPTURE: begin
        if (axis.s_axis_tvalid && !fifo_full) begin
          wr_en    = 1'b1;
          wr_entry = {(smp_cnt == LAST_IDX), 2'b00, axis.s_axis_tdata};
        end
      end
      ABORT: begin
        if (!fifo_full) begin
          wr_en    = 1'b1;
          wr_entry = {3'b110, {TW{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  // Frame capture FSM with registered status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      smp_cnt     <= '0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sof) begin
            if (!fifo_full) begin
              state   <= CAPTURE;
              smp_cnt <= SW'(1);
              o_busy  <= 1'b1;
            end else begin
              o_overflow <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (axis.s_axis_tvalid) begin
            if (fifo_full) begin
              o_overflow <= 1'b1;
              state      <= ABORT;
            end else if (smp_cnt == LAST_IDX) begin
              state       <= IDLE;
              smp_cnt     <= '0;
              o_busy      <= 1'b0;
              o_frame_cnt <= o_frame_cnt + PAR_CNT_WIDTH'(1);
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
        end
        ABORT: begin
          if (!fifo_full) begin
            state   <= IDLE;
            smp_cnt <= '0;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; stale contents are harmless because pointers are reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_entry;
  end

  // Pointer update and registered first-word-fall-through output stage.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      axis.m_axis_tvalid <= 1'b0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tuser  <= '0;
      axis.m_axis_tlast  <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr_n;
      rd_ptr             <= rd_ptr_n;
      axis.m_axis_tvalid <= !fifo_empty_n;
      if (!fifo_empty_n)
        {axis.m_axis_tlast, axis.m_axis_tuser, axis.m_axis_tdata} <= head_n;
    end
  end

endmodule

// File: tb/tb_ais_frame_gate.sv
// Directed bench for ais_frame_gate with 20-sample frames and an 8-deep FIFO.
module tb_ais_frame_gate;
  localparam int DW = 16;
  localparam int N  = 20;
  localparam int D  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy, ovf;
  logic [CW-1:0] fcnt;

  int          checks = 0;
  int          errors = 0;
  logic [34:0] q[$];
  bit          rnd_ready = 1'b0;
  int          sofs[$];

  always #5 clk = ~clk;

  ais_frame_gate_if #(.PAR_DATA_WIDTH(DW)) bus ();

  ais_frame_gate #(
    .PAR_DATA_WIDTH(DW), .PAR_FRAME_SAMPLES(N),
    .PAR_FIFO_DEPTH(D), .PAR_CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .axis(bus.slave),
    .o_busy(busy), .o_overflow(ovf), .o_frame_cnt(fcnt)
  );

  // Record each output handshake (it completes at the following rising edge).
  always @(negedge clk) begin
    if (rst_n && bus.m_axis_tvalid && bus.m_axis_tready)
      q.push_back({bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata});
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] iq(int n);
    logic [15:0] i_v;
    i_v = 16'(n);
    return {i_v ^ 16'h5A5A, i_v};
  endfunction

  function automatic bit is_sof(int n);
    foreach (sofs[k]) if (sofs[k] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int n, bit sof);
    bus.s_axis_tvalid = v;
    bus.s_axis_tdata  = v ? iq(n) : 32'h0;
    bus.s_axis_tuser  = sof;
    if (rnd_ready) bus.m_axis_tready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic stream(int from, int to, int gap);
    for (int n = from; n <= to; n++) begin
      drive(1'b1, n, is_sof(n));
      repeat (gap) drive(1'b0, 0, 1'b0);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tuser  = 1'b0;
  endtask

  task automatic idle(int cycles);
    repeat (cycles) drive(1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic check_frame(string tag, int base);
    logic [34:0] e, exp;
    for (int i = 0; i < N; i++) begin
      exp = {(i == N - 1), 1'b0, (i == 0), iq(base + i)};
      if (q.size() == 0) e = 'x;
      else e = q.pop_front();
      chk(tag, 64'(e), 64'(exp));
    end
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tuser  = 1'b0;
    bus.m_axis_tready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    chk("rst_tout", 64'({bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_fcnt", 64'(fcnt), 64'(0));

    // Test 1: single frame, SOF at sample 10, continuous ready
    sofs = '{10};
    stream(0, 9, 0);
    chk("t1_pre_valid", 64'(bus.m_axis_tvalid), 64'(0));
    stream(10, 10, 0);
    chk("t1_lat_valid", 64'(bus.m_axis_tvalid), 64'(1));
    chk("t1_lat_data", 64'(bus.m_axis_tdata), 64'(iq(10)));
    chk("t1_lat_user", 64'(bus.m_axis_tuser), 64'(2'b01));
    chk("t1_busy", 64'(busy), 64'(1));
    stream(11, 99, 0);
    idle(5);
    chk("t1_count", 64'(q.size()), 64'(N));
    check_frame("t1_frame", 10);
    chk("t1_fcnt", 64'(fcnt), 64'(1));
    chk("t1_ovf", 64'(ovf), 64'(0));
    chk("t1_idle", 64'(busy), 64'(0));

    // Test 2: re-detects inside a frame ignored, SOF at 29 ignored, SOF at 30 starts
    do_reset();
    chk("t2_rst_fcnt", 64'(fcnt), 64'(0));
    sofs = '{10, 15, 29, 30};
    stream(0, 99, 0);
    idle(5);
    chk("t2_count", 64'(q.size()), 64'(2 * N));
    check_frame("t2_frame_a", 10);
    check_frame("t2_frame_b", 30);
    chk("t2_fcnt", 64'(fcnt), 64'(2));
    chk("t2_ovf", 64'(ovf), 64'(0));

    // Test 3: stalled output fills FIFO, frame aborted
    do_reset();
    bus.m_axis_tready = 1'b0;
    sofs = '{10};
    stream(0, 17, 0);
    chk("t3_ovf_pre", 64'(ovf), 64'(0));
    stream(18, 18, 0);
    chk("t3_ovf", 64'(ovf), 64'(1));
    chk("t3_busy_abort", 64'(busy), 64'(1));
    stream(19, 25, 0);
    chk("t3_hold_valid", 64'(bus.m_axis_tvalid), 64'(1));
    chk("t3_hold_data", 64'(bus.m_axis_tdata), 64'(iq(10)));
    chk("t3_hold_user", 64'(bus.m_axis_tuser), 64'(2'b01));
    chk("t3_still_abort", 64'(busy), 64'(1));
    bus.m_axis_tready = 1'b1;
    idle(15);
    chk("t3_count", 64'(q.size()), 64'(D + 1));
    for (int i = 0; i < D; i++) begin
      logic [34:0] e;
      if (q.size() == 0) e = 'x;
      else e = q.pop_front();
      chk("t3_held", 64'(e), 64'({1'b0, 1'b0, (i == 0), iq(10 + i)}));
    end
    begin
      logic [34:0] e;
      if (q.size() == 0) e = 'x;
      else e = q.pop_front();
      chk("t3_abort_entry", 64'(e), 64'({1'b1, 2'b10, 32'h0}));
    end
    chk("t3_fcnt", 64'(fcnt), 64'(0));
    chk("t3_busy_end", 64'(busy), 64'(0));

    // Test 4: sparse input, random ready, five frames
    do_reset();
    sofs = '{5, 75, 145, 215, 285};
    rnd_ready = 1'b1;
    stream(0, 309, 2);
    rnd_ready = 1'b0;
    bus.m_axis_tready = 1'b1;
    idle(30);
    chk("t4_count", 64'(q.size()), 64'(5 * N));
    foreach (sofs[k]) check_frame("t4_frame", sofs[k]);
    chk("t4_fcnt", 64'(fcnt), 64'(5));
    chk("t4_ovf", 64'(ovf), 64'(0));

    // Test 5: reset at frame sample 7 discards the frame
    q.delete();
    sofs = '{400};
    stream(400, 406, 0);
    rst_n = 1'b0;
    drive(1'b1, 407, 1'b0);
    rst_n = 1'b1;
    chk("t5_tvalid", 64'(bus.m_axis_tvalid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_fcnt", 64'(fcnt), 64'(0));
    q.delete();
    sofs = '{420};
    stream(408, 449, 0);
    idle(5);
    chk("t5_count", 64'(q.size()), 64'(N));
    check_frame("t5_frame", 420);
    chk("t5_fcnt_new", 64'(fcnt), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
